// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         DEF_MEM_TIMEOUT = 255;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID source that depends on a load in EX.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       ex_MemRead,
    input  logic [4:0] ex_write_addr,
    output logic       lu_hazard
);

    logic [1:0][4:0] src_addr;
    logic [1:0]      src_use;
    logic [1:0]      src_match;

    assign src_addr = {id_rt_addr, id_rs_addr};
    assign src_use  = {id_uses_rt, id_uses_rs};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_use[gi] && (src_addr[gi] == ex_write_addr);
        end
    endgenerate

    // $zero is never really written, so a load targeting it cannot create a dependency.
    assign lu_hazard = ex_MemRead && (ex_write_addr != REG_ZERO) && (|src_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: memory-wait freeze, EX branch flush, load-use bubble.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_write_addr,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_wr,
    output logic             ifid_wr,
    output logic             ifid_flush,
    output logic             idex_wr_en,
    output logic             idex_flush,
    output logic             exmem_wr,
    output logic             memwb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t            state_reg, state_next;
    logic [TO_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic              mem_err_reg, mem_err_next;
    logic              lu_hazard;
    logic              run_eval;

    load_use_detect u_load_use_detect (
        .id_rs_addr    (id_rs_addr),
        .id_rt_addr    (id_rt_addr),
        .id_uses_rs    (id_uses_rs),
        .id_uses_rt    (id_uses_rt),
        .ex_MemRead    (ex_MemRead),
        .ex_write_addr (ex_write_addr),
        .lu_hazard     (lu_hazard)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            mem_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        mem_err_next  = mem_err_reg;
        run_eval      = 1'b0;
        pc_wr         = 1'b0;
        ifid_wr       = 1'b0;
        ifid_flush    = 1'b0;
        idex_wr_en    = 1'b0;
        idex_flush    = 1'b0;
        exmem_wr      = 1'b0;
        memwb_flush   = 1'b0;

        if (reset) begin
            case (state_reg)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        memwb_flush   = 1'b1;
                        state_next    = MEM_WAIT;
                        wait_cnt_next = TO_W'(1);
                    end else begin
                        run_eval = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        run_eval      = 1'b1;
                        state_next    = RUN;
                        wait_cnt_next = '0;
                    end else if (wait_cnt_reg == TO_W'(MEM_TIMEOUT)) begin
                        // Abort: let the pipeline move on and drop the stuck access.
                        pc_wr         = 1'b1;
                        ifid_wr       = 1'b1;
                        idex_wr_en    = 1'b1;
                        exmem_wr      = 1'b1;
                        memwb_flush   = 1'b1;
                        mem_err_next  = 1'b1;
                        state_next    = RUN;
                        wait_cnt_next = '0;
                    end else begin
                        memwb_flush   = 1'b1;
                        wait_cnt_next = wait_cnt_reg + TO_W'(1);
                    end
                end
                default: state_next = RUN;
            endcase

            // Branch outranks load-use: the flush removes the dependent instruction anyway.
            if (run_eval) begin
                pc_wr      = 1'b1;
                ifid_wr    = 1'b1;
                idex_wr_en = 1'b1;
                exmem_wr   = 1'b1;
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu_hazard) begin
                    pc_wr      = 1'b0;
                    ifid_wr    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
        end
    end

    assign mem_err = mem_err_reg;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (!pc_wr)
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (ifid_flush || idex_flush)
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT=4).
module tb_hazard_stall_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_wr, ifid_wr, ifid_flush, idex_wr_en, idex_flush, exmem_wr, memwb_flush}
    localparam logic [6:0] C_OFF    = 7'b0000000;
    localparam logic [6:0] C_NORMAL = 7'b1101010;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_BRANCH = 7'b1111110;
    localparam logic [6:0] C_LU     = 7'b0001110;
    localparam logic [6:0] C_ABORT  = 7'b1101011;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs_addr, id_rt_addr, ex_write_addr;
    logic        id_uses_rs, id_uses_rt, ex_MemRead, ex_branch_taken;
    logic        mem_req, mem_ready;
    logic        pc_wr, ifid_wr, ifid_flush, idex_wr_en, idex_flush, exmem_wr, memwb_flush;
    logic        mem_err;
    logic [31:0] stall_cnt, flush_cnt;
    logic [6:0]  ctl;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_wr, ifid_wr, ifid_flush, idex_wr_en, idex_flush, exmem_wr, memwb_flush};

    hazard_stall_ctrl #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_MemRead      (ex_MemRead),
        .ex_write_addr   (ex_write_addr),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_wr           (pc_wr),
        .ifid_wr         (ifid_wr),
        .ifid_flush      (ifid_flush),
        .idex_wr_en      (idex_wr_en),
        .idex_flush      (idex_flush),
        .exmem_wr        (exmem_wr),
        .memwb_flush     (memwb_flush),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the control vector for the current cycle, then let the edge happen.
    task automatic cyc(input string tag, input logic [6:0] exp);
        #1;
        chk(tag, {25'd0, ctl}, {25'd0, exp});
        step();
    endtask

    task automatic idle();
        id_rs_addr      = 5'd0;
        id_rt_addr      = 5'd0;
        id_uses_rs      = 1'b0;
        id_uses_rt      = 1'b0;
        ex_MemRead      = 1'b0;
        ex_write_addr   = 5'd0;
        ex_branch_taken = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        idle();
        reset   = 1'b0;
        mem_req = 1'b1;
        step();
        cyc("rst_hold0", C_OFF);
        cyc("rst_hold1", C_OFF);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);

        reset   = 1'b1;
        mem_req = 1'b0;
        cyc("run_after_rst", C_NORMAL);

        // Load-use on rs, then the load moves on.
        ex_MemRead = 1'b1; ex_write_addr = 5'd8; id_rs_addr = 5'd8; id_uses_rs = 1'b1;
        cyc("lu_rs", C_LU);
        ex_MemRead = 1'b0;
        cyc("lu_rs_done", C_NORMAL);
        // Load-use on rt.
        ex_MemRead = 1'b1; id_rs_addr = 5'd3; id_rt_addr = 5'd8; id_uses_rt = 1'b1;
        cyc("lu_rt", C_LU);
        // Address match but no source read.
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_rs_addr = 5'd8;
        cyc("lu_unused", C_NORMAL);
        // Load into $zero never stalls.
        ex_write_addr = 5'd0; id_rs_addr = 5'd0; id_uses_rs = 1'b1;
        cyc("lu_zero", C_NORMAL);
        // Branch and load-use together.
        ex_write_addr = 5'd8; id_rs_addr = 5'd8; ex_branch_taken = 1'b1;
        cyc("branch_lu", C_BRANCH);
        idle();
        chk("flush_cnt_3", flush_cnt, PERF ? 32'd3 : 32'd0);
        chk("stall_cnt_2", stall_cnt, PERF ? 32'd2 : 32'd0);

        // Memory wait: three frozen cycles, release on the fourth.
        pulse_reset();
        mem_req = 1'b1;
        cyc("mw_freeze1", C_FREEZE);
        cyc("mw_freeze2", C_FREEZE);
        cyc("mw_freeze3", C_FREEZE);
        mem_ready = 1'b1;
        cyc("mw_release", C_NORMAL);
        idle();
        cyc("mw_after", C_NORMAL);
        chk("mw_stall_cnt", stall_cnt, PERF ? 32'd3 : 32'd0);
        chk("mw_mem_err", {31'd0, mem_err}, 32'd0);

        // Release cycle still honours a taken branch.
        mem_req = 1'b1;
        cyc("mwb_freeze", C_FREEZE);
        mem_ready = 1'b1; ex_branch_taken = 1'b1;
        cyc("mwb_release", C_BRANCH);
        idle();

        // Timeout: abort on the fourth MEM_WAIT cycle.
        mem_req = 1'b1;
        cyc("to_freeze1", C_FREEZE);
        cyc("to_freeze2", C_FREEZE);
        cyc("to_freeze3", C_FREEZE);
        cyc("to_freeze4", C_FREEZE);
        chk("to_pre_err", {31'd0, mem_err}, 32'd0);
        cyc("to_abort", C_ABORT);
        chk("to_err_set", {31'd0, mem_err}, 32'd1);
        mem_req = 1'b0;
        cyc("to_run", C_NORMAL);
        cyc("to_run2", C_NORMAL);
        chk("to_err_sticky", {31'd0, mem_err}, 32'd1);

        // mem_ready on the timeout cycle wins.
        pulse_reset();
        chk("rdy_err_clr", {31'd0, mem_err}, 32'd0);
        mem_req = 1'b1;
        cyc("rdy_freeze1", C_FREEZE);
        cyc("rdy_freeze2", C_FREEZE);
        cyc("rdy_freeze3", C_FREEZE);
        cyc("rdy_freeze4", C_FREEZE);
        mem_ready = 1'b1;
        cyc("rdy_release", C_NORMAL);
        chk("rdy_no_err", {31'd0, mem_err}, 32'd0);

        // Reset on the cycle that would have timed out.
        mem_ready = 1'b0;
        cyc("rw_freeze1", C_FREEZE);
        cyc("rw_freeze2", C_FREEZE);
        cyc("rw_freeze3", C_FREEZE);
        cyc("rw_freeze4", C_FREEZE);
        reset = 1'b0;
        cyc("rw_in_reset", C_OFF);
        reset   = 1'b1;
        mem_req = 1'b0;
        cyc("rw_back_run", C_NORMAL);
        chk("rw_no_err", {31'd0, mem_err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage MIPS core.
- Drives write enables and flushes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three conditions with fixed priority: multi-cycle data-memory waits (freeze), taken branch/jump in EX (flush), and load-use hazards (one-bubble stall).
- Sits beside the pipeline registers; all control outputs are same-cycle combinational from registered FSM state plus current inputs.

Parameters:
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before the controller aborts the access.
- TO_W, 8: width of the wait counter; MEM_TIMEOUT must be < 2^TO_W.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- id_rs_addr  in  5  rs field of the instruction in ID
- id_rt_addr  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_MemRead  in  1  instruction in EX is a load
- ex_write_addr  in  5  destination register of the EX instruction
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- mem_req  in  1  MEM-stage instruction accesses data memory (MemRead|MemWrite)
- mem_ready  in  1  data memory completes the access this cycle
- pc_wr  out  1  PC write enable
- ifid_wr  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID flush (load NOP)
- idex_wr_en  out  1  ID/EX write enable
- idex_flush  out  1  ID/EX flush (bubble: clears MemRead/MemWrite/RegWrite)
- exmem_wr  out  1  EX/MEM write enable
- memwb_flush  out  1  MEM/WB loads a bubble
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt  out  CNT_W  stall-cycle counter (optional feature)
- flush_cnt  out  CNT_W  flush-event counter (optional feature)

Behaviour:
- Reset is synchronous and active-low on clk: reset==0 sampled at a posedge forces state RUN, wait_cnt=0, mem_err=0, counters=0.
- While reset==0, outputs are combinationally forced: all *_wr/_wr_en=0, all flushes=0.
- FSM states: RUN and MEM_WAIT.

RUN:
- A memory wait is detected when mem_req && !mem_ready.
  - Outputs: freeze. pc_wr=ifid_wr=idex_wr_en=exmem_wr=0, memwb_flush=1.
  - Next state MEM_WAIT, wait_cnt←1.
  - Branch and load-use are ignored this cycle.
- Otherwise, if ex_branch_taken: ifid_flush=1, idex_flush=1, all enables=1.
- Otherwise, load-use is detected when ex_MemRead && ex_write_addr!=0 && ((id_uses_rs && id_rs_addr==ex_write_addr) || (id_uses_rt && id_rt_addr==ex_write_addr)).
  - Outputs: pc_wr=0, ifid_wr=0, idex_wr_en=1, idex_flush=1, exmem_wr=1.
  - The stall lasts exactly one cycle, since the load advances to MEM.
- Otherwise, all enables=1 and no flush.

MEM_WAIT:
- Pipeline frozen with RUN-freeze outputs; wait_cnt increments each cycle.
- mem_ready==1: release this cycle.
  - All enables=1, memwb_flush=0.
  - Branch and load-use are evaluated exactly as in RUN, except that the memory-wait condition is not re-checked.
  - Next state RUN.
- wait_cnt==MEM_TIMEOUT without mem_ready: abort.
  - mem_err←1 (sticky until reset).
  - All enables=1 and memwb_flush=1 (the aborted access is dropped).
  - Next state RUN.
- mem_ready and timeout in the same cycle: mem_ready wins, mem_err is not set.

Boundaries:
- ex_write_addr==0 never stalls.
- Branch and load-use in the same cycle: branch wins; the flush removes the dependent instruction.
- Reset mid-MEM_WAIT aborts with no mem_err.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with pc_wr==0 while reset==1.
  - flush_cnt increments on every cycle with ifid_flush||idex_flush.
  - Both counters wrap at 2^CNT_W.
- Undefined: both outputs tied to 0 and no counter flops are built.

Decomposition:
- Shared package hazard_pkg holds:
  - state enum (RUN=1'b0, MEM_WAIT=1'b1);
  - REG_ZERO=5'd0;
  - default MEM_TIMEOUT.
- Sub-module load_use_detect: purely combinational comparator producing lu_hazard, instantiated once.

Test Plan:
- Reset: hold reset=0 for 2 cycles with mem_req=1 → all enables 0, mem_err=0, counters 0; release → state RUN, all enables 1.
- Load-use: ex_MemRead=1, ex_write_addr=8, id_rs_addr=8, id_uses_rs=1 → one cycle with pc_wr=0, ifid_wr=0, idex_flush=1. Repeat with ex_write_addr=0 → no stall.
- Branch plus load-use in the same cycle → ifid_flush=1, idex_flush=1, pc_wr=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 → 3 frozen cycles with memwb_flush=1, release on the 4th; with the feature on, stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_ready stuck 0 → abort on the 4th wait cycle, mem_err=1 stays set; mem_ready arriving in the same cycle as wait_cnt==4 → no error.
- Reset asserted during MEM_WAIT → next cycle RUN, mem_err=0.
